paddle_ctrl: RTL and testbench

Downstream consumer of the keypad scanner's 5-bit `keycode`. The block synchronises the code, turns changes of the 4-bit key value into key events, and runs a small game-state FSM (IDLE/RUN/PAUSE). It also keeps two latched paddle-direction FSMs and moves the left and right paddle Y positions on a prescaled movement tick. Its outputs feed the Pong renderer and ball/collision logic.

---
 rtl/pong_pkg.sv | 52 +++++
 rtl/key_event_detect.sv | 43 ++++
 rtl/paddle_ctrl.sv | 135 +++++++++++++
 tb/tb_paddle_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared key codes, direction/game-state types and the direction-key decoder
// used by the paddle controller.
package pong_pkg;

  localparam logic [3:0] KEY_L_UP   = 4'd1;
  localparam logic [3:0] KEY_L_STOP = 4'd4;
  localparam logic [3:0] KEY_L_DN   = 4'd7;
  localparam logic [3:0] KEY_R_UP   = 4'd10;
  localparam logic [3:0] KEY_R_STOP = 4'd11;
  localparam logic [3:0] KEY_R_DN   = 4'd12;
  localparam logic [3:0] KEY_START  = 4'd5;
  localparam logic [3:0] KEY_PAUSE  = 4'd0;
  localparam logic [3:0] KEY_RESET  = 4'd14;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } dir_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } game_state_t;

  typedef struct packed {
    logic hit;
    dir_t dir;
  } dir_cmd_t;

  // Map a key value onto one paddle's direction command; hit=0 for foreign keys.
  function automatic dir_cmd_t decode_dir(
    input logic [3:0] key,
    input logic [3:0] k_up,
    input logic [3:0] k_stop,
    input logic [3:0] k_dn
  );
    dir_cmd_t c;
    c.hit = 1'b1;
    c.dir = STOP;
    if (key == k_up) begin
      c.dir = UP;
    end else if (key == k_dn) begin
      c.dir = DOWN;
    end else if (key != k_stop) begin
      c.hit = 1'b0;
    end
    return c;
  endfunction

endpackage

// File: rtl/key_event_detect.sv
// Two-flop synchroniser for the scanner key value plus change detection.
// key_evt is combinational on the synchronised value so the consumer can act on the same edge.
module key_event_detect (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_in,
  output logic [3:0] key_val,
  output logic       key_evt
);

  logic [3:0] s1_reg;
  logic [3:0] s2_reg;
  logic [3:0] prev_reg;
  logic       s1_valid_reg;
  logic       s2_valid_reg;
  logic       prev_valid_reg;

  assign key_val = s2_reg;
  assign key_evt = prev_valid_reg && (s2_reg != prev_reg);

  // The valid bits keep the post-reset flush of s1/s2 from posing as a real
  // sample, so a key held across reset only primes prev.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg         <= '0;
      s2_reg         <= '0;
      prev_reg       <= '0;
      s1_valid_reg   <= 1'b0;
      s2_valid_reg   <= 1'b0;
      prev_valid_reg <= 1'b0;
    end else begin
      s1_reg       <= key_in;
      s1_valid_reg <= 1'b1;
      s2_reg       <= s1_reg;
      s2_valid_reg <= s1_valid_reg;
      if (s2_valid_reg) begin
        prev_reg       <= s2_reg;
        prev_valid_reg <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Keypad-driven game state, paddle direction latching and saturating paddle
// movement on a prescaled tick for the Pong renderer.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int Y_MAX    = 480,
  parameter int PAD_H    = 64,
  parameter int STEP     = 4,
  parameter int TICK_DIV = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] keycode,
  output logic [9:0] pad_l_y,
  output logic [9:0] pad_r_y,
  output logic [1:0] dir_l,
  output logic [1:0] dir_r,
  output logic       run,
  output logic       key_evt
);

  localparam int         CW     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [9:0] Y_LIM  = 10'(Y_MAX - PAD_H);
  localparam logic [9:0] CENTER = 10'((Y_MAX - PAD_H) / 2);
  localparam logic [9:0] STEP_V = 10'(STEP);

  logic [3:0] key_val;
  logic       evt;

  key_event_detect u_key_event_detect (
    .clk     (clk),
    .rst     (rst),
    .key_in  (keycode[4:1]),
    .key_val (key_val),
    .key_evt (evt)
  );

  // The scanner's flag bit carries nothing for this block.
  logic flag_unused;
  assign flag_unused = keycode[0];

  game_state_t state_reg;
  logic [CW-1:0] cnt_reg;
  logic          key_evt_reg;
  logic          tick;
  logic          round_reset;
  logic          move_en;

  assign tick        = (cnt_reg == CW'(TICK_DIV - 1));
  assign round_reset = evt && (key_val == KEY_RESET);
  assign move_en     = tick && (state_reg == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      key_evt_reg <= 1'b0;
    end else begin
      cnt_reg     <= tick ? '0 : cnt_reg + CW'(1);
      key_evt_reg <= evt;
      if (evt) begin
        if (key_val == KEY_RESET) begin
          state_reg <= IDLE;
        end else begin
          case (state_reg)
            IDLE:    if (key_val == KEY_START) state_reg <= RUN;
            RUN:     if (key_val == KEY_PAUSE) state_reg <= PAUSE;
            PAUSE:   if (key_val == KEY_START) state_reg <= RUN;
            default: state_reg <= IDLE;
          endcase
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_pad
      localparam logic [3:0] K_UP   = (gi == 0) ? KEY_L_UP   : KEY_R_UP;
      localparam logic [3:0] K_STOP = (gi == 0) ? KEY_L_STOP : KEY_R_STOP;
      localparam logic [3:0] K_DN   = (gi == 0) ? KEY_L_DN   : KEY_R_DN;

      logic [9:0]  y_reg;
      dir_t        dir_reg;
      dir_cmd_t    cmd;
      logic [9:0]  y_next;
      logic [10:0] y_sum;
      logic        at_limit;

      always_comb begin
        cmd = decode_dir(key_val, K_UP, K_STOP, K_DN);
      end

      always_comb begin
        y_next   = y_reg;
        y_sum    = {1'b0, y_reg} + {1'b0, STEP_V};
        at_limit = 1'b0;
        case (dir_reg)
          UP: begin
            y_next   = (y_reg >= STEP_V) ? (y_reg - STEP_V) : 10'd0;
            at_limit = (y_next == 10'd0);
          end
          DOWN: begin
            y_next   = (y_sum >= {1'b0, Y_LIM}) ? Y_LIM : y_sum[9:0];
            at_limit = (y_next == Y_LIM);
          end
          default: ;
        endcase
      end

      // Tick uses the pre-edge direction; a direction key overrides the limit stop.
      always_ff @(posedge clk) begin
        if (rst || round_reset) begin
          y_reg   <= CENTER;
          dir_reg <= STOP;
        end else begin
          if (move_en) begin
            y_reg <= y_next;
            if (at_limit) dir_reg <= STOP;
          end
          if (evt && (state_reg != IDLE) && cmd.hit) begin
            dir_reg <= cmd.dir;
          end
        end
      end
    end
  endgenerate

  assign pad_l_y = g_pad[0].y_reg;
  assign pad_r_y = g_pad[1].y_reg;
  assign dir_l   = g_pad[0].dir_reg;
  assign dir_r   = g_pad[1].dir_reg;
  assign run     = (state_reg == RUN);
  assign key_evt = key_evt_reg;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Self-checking bench for paddle_ctrl with TICK_DIV=4: key-event table plus
// hand-timed movement, limit, pause, round-reset and mid-run reset sequences.
module tb_paddle_ctrl;
  import pong_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] keycode;
  logic [9:0] pad_l_y;
  logic [9:0] pad_r_y;
  logic [1:0] dir_l;
  logic [1:0] dir_r;
  logic       run;
  logic       key_evt;

  paddle_ctrl #(.TICK_DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .keycode (keycode),
    .pad_l_y (pad_l_y),
    .pad_r_y (pad_r_y),
    .dir_l   (dir_l),
    .dir_r   (dir_r),
    .run     (run),
    .key_evt (key_evt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Independent prescaler phase: value after each edge, 0 right after a tick edge.
  int tb_cnt = 0;
  always @(posedge clk) begin
    if (rst) tb_cnt <= 0;
    else     tb_cnt <= (tb_cnt == 3) ? 0 : tb_cnt + 1;
  end

  // Counts every cycle key_evt is high; a stretched pulse shows up as an extra count.
  int evt_total = 0;
  int exp_evt_total = 0;
  always @(posedge clk) begin
    evt_total <= evt_total + int'(key_evt);
  end

  typedef struct {
    logic       evt;
    logic       run;
    logic [1:0] dl;
    logic [1:0] dr;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0] key;
    logic       flag;
    logic       evt;
    logic       run;
    logic [1:0] dl;
    logic [1:0] dr;
    logic       chk_y;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_pos(input int el, input int er);
    chk("pad_l_y", int'(pad_l_y), el);
    chk("pad_r_y", int'(pad_r_y), er);
  endtask

  // Return at the negedge following an edge whose pre-edge prescaler phase was ph.
  task automatic align(input int ph);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tb_cnt != (ph + 1) % 4 && n < 8);
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tb_cnt != 0 && n < 8);
  endtask

  task automatic press(input logic [3:0] k, input logic flag, input int ph,
                       input logic e_evt, input logic e_run,
                       input logic [1:0] e_dl, input logic [1:0] e_dr);
    exp_t x;
    int   edges = 0;
    bit   seen  = 1'b0;
    align(ph);
    chk("evt_count", evt_total, exp_evt_total);
    keycode = {k, flag};
    x.evt = e_evt; x.run = e_run; x.dl = e_dl; x.dr = e_dr;
    sb.push_back(x);
    if (e_evt) exp_evt_total++;
    while (!seen && edges < (e_evt ? 8 : 6)) begin
      @(negedge clk);
      edges++;
      if (key_evt) seen = 1'b1;
    end
    x = sb.pop_front();
    chk("key_evt", int'(seen), int'(x.evt));
    if (x.evt) chk("evt_latency", edges, 3);
    chk("run", int'(run), int'(x.run));
    chk("dir_l", int'(dir_l), int'(x.dl));
    chk("dir_r", int'(dir_r), int'(x.dr));
    $display("key %0d: evt=%0d run=%0d dir_l=%0d dir_r=%0d l_y=%0d r_y=%0d",
             k, seen, run, dir_l, dir_r, pad_l_y, pad_r_y);
  endtask

  initial begin
    //            key    flag  evt   run   dl    dr    chk_y
    tbl[0]  = '{4'd3,  1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1};
    tbl[1]  = '{4'd1,  1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1};
    tbl[2]  = '{4'd0,  1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1};
    tbl[3]  = '{4'd5,  1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b1};
    tbl[4]  = '{4'd5,  1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1};
    tbl[5]  = '{4'd10, 1'b0, 1'b1, 1'b1, 2'd0, 2'd1, 1'b0};
    tbl[6]  = '{4'd7,  1'b0, 1'b1, 1'b1, 2'd2, 2'd1, 1'b0};
    tbl[7]  = '{4'd9,  1'b0, 1'b1, 1'b1, 2'd2, 2'd1, 1'b0};
    tbl[8]  = '{4'd11, 1'b0, 1'b1, 1'b1, 2'd2, 2'd0, 1'b0};
    tbl[9]  = '{4'd0,  1'b0, 1'b1, 1'b0, 2'd2, 2'd0, 1'b0};
    tbl[10] = '{4'd12, 1'b0, 1'b1, 1'b0, 2'd2, 2'd2, 1'b0};
    tbl[11] = '{4'd5,  1'b0, 1'b1, 1'b1, 2'd2, 2'd2, 1'b0};
    tbl[12] = '{4'd4,  1'b0, 1'b1, 1'b1, 2'd0, 2'd2, 1'b0};
    tbl[13] = '{4'd5,  1'b0, 1'b1, 1'b1, 2'd0, 2'd2, 1'b0};
    tbl[14] = '{4'd14, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1};
    tbl[15] = '{4'd5,  1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b1};

    // Reset with key 5 held: reset values, and no event once released.
    rst     = 1'b1;
    keycode = {4'd5, 1'b0};
    repeat (3) @(negedge clk);
    chk_pos(208, 208);
    chk("rst_run", int'(run), 0);
    chk("rst_dir_l", int'(dir_l), 0);
    chk("rst_dir_r", int'(dir_r), 0);
    chk("rst_key_evt", int'(key_evt), 0);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("no_evt_after_reset", int'(key_evt), 0);
    end
    chk_pos(208, 208);
    chk("run_after_reset", int'(run), 0);

    for (int i = 0; i < 16; i++) begin
      press(tbl[i].key, tbl[i].flag, 3, tbl[i].evt, tbl[i].run, tbl[i].dl, tbl[i].dr);
      if (tbl[i].chk_y) chk_pos(208, 208);
    end

    // Left paddle down from center, then stop (the alignment tick adds one more step).
    press(4'd7, 1'b0, 3, 1'b1, 1'b1, 2'd2, 2'd0);
    for (int i = 1; i <= 3; i++) begin
      wait_tick();
      chk_pos(208 + 4 * i, 208);
    end
    press(4'd4, 1'b0, 3, 1'b1, 1'b1, 2'd0, 2'd0);
    chk_pos(224, 208);

    // Left paddle up to the top limit.
    press(4'd1, 1'b0, 3, 1'b1, 1'b1, 2'd1, 2'd0);
    for (int i = 1; i <= 57; i++) begin
      wait_tick();
      chk("top_pad_l_y", int'(pad_l_y), (i >= 56) ? 0 : 224 - 4 * i);
      chk("top_dir_l", int'(dir_l), (i >= 56) ? 0 : 1);
    end

    // Right paddle down to the bottom limit.
    press(4'd12, 1'b0, 3, 1'b1, 1'b1, 2'd0, 2'd2);
    for (int i = 1; i <= 53; i++) begin
      wait_tick();
      chk("bot_pad_r_y", int'(pad_r_y), (i >= 52) ? 416 : 208 + 4 * i);
      chk("bot_dir_r", int'(dir_r), (i >= 52) ? 0 : 2);
    end
    chk_pos(0, 416);

    // DOWN while already at the bottom: y holds, direction drops to STOP.
    press(4'd11, 1'b0, 3, 1'b1, 1'b1, 2'd0, 2'd0);
    press(4'd12, 1'b0, 3, 1'b1, 1'b1, 2'd0, 2'd2);
    wait_tick();
    chk_pos(0, 416);
    chk("at_limit_dir_r", int'(dir_r), 0);

    // Limit-stop and direction key on the same tick: the key wins.
    press(4'd10, 1'b0, 3, 1'b1, 1'b1, 2'd0, 2'd1);
    wait_tick();
    chk_pos(0, 412);
    press(4'd12, 1'b0, 3, 1'b1, 1'b1, 2'd0, 2'd2);
    chk_pos(0, 408);
    press(4'd10, 1'b0, 0, 1'b1, 1'b1, 2'd0, 2'd1);
    chk_pos(0, 416);
    wait_tick();
    chk_pos(0, 412);
    chk("key_wins_dir_r", int'(dir_r), 1);
    press(4'd11, 1'b0, 3, 1'b1, 1'b1, 2'd0, 2'd0);
    chk_pos(0, 408);

    // Pause freezes movement but still latches directions; resume moves both.
    press(4'd7, 1'b0, 3, 1'b1, 1'b1, 2'd2, 2'd0);
    chk_pos(0, 408);
    press(4'd0, 1'b0, 3, 1'b1, 1'b0, 2'd2, 2'd0);
    chk_pos(4, 408);
    repeat (2) begin
      wait_tick();
      chk_pos(4, 408);
    end
    press(4'd10, 1'b0, 3, 1'b1, 1'b0, 2'd2, 2'd1);
    chk_pos(4, 408);
    wait_tick();
    chk_pos(4, 408);
    press(4'd5, 1'b0, 3, 1'b1, 1'b1, 2'd2, 2'd1);
    chk_pos(4, 408);
    wait_tick();
    chk_pos(8, 404);

    // Round reset landing on a tick: centering wins, then direction keys are ignored.
    press(4'd14, 1'b0, 0, 1'b1, 1'b0, 2'd0, 2'd0);
    chk_pos(208, 208);
    press(4'd1, 1'b0, 3, 1'b1, 1'b0, 2'd0, 2'd0);
    chk_pos(208, 208);

    // Reset in the middle of movement.
    press(4'd5, 1'b0, 3, 1'b1, 1'b1, 2'd0, 2'd0);
    press(4'd7, 1'b0, 3, 1'b1, 1'b1, 2'd2, 2'd0);
    wait_tick();
    chk_pos(212, 208);
    rst = 1'b1;
    @(negedge clk);
    chk_pos(208, 208);
    chk("midrst_dir_l", int'(dir_l), 0);
    chk("midrst_run", int'(run), 0);
    chk("midrst_key_evt", int'(key_evt), 0);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("no_evt_after_midrst", int'(key_evt), 0);
    end
    chk_pos(208, 208);
    press(4'd5, 1'b0, 3, 1'b1, 1'b1, 2'd0, 2'd0);
    repeat (2) @(negedge clk);
    chk("evt_count_final", evt_total, exp_evt_total);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
